// File: rtl/lfsr_rr_ctrl.sv
// Shares one 5-bit LFSR between two round-robin requesters. Each grant advances
// the LFSR STEPS times and returns the resulting value with a one-cycle ack.
module lfsr_rr_ctrl #(
  parameter int unsigned STEPS = 3
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [1:0] req,
  input  logic       seed_ld,
  input  logic [4:0] seed,
  output logic [1:0] ack,
  output logic [4:0] data,
  output logic       busy
);

  localparam int unsigned LW = 5;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   s;
  logic [LW-1:0]   s_nxt;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            g;

  // One LFSR advance; the xor tap feeds s2
  always_comb begin
    s_nxt = {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      s     <= '1;
      cnt   <= '0;
      last  <= 1'b1;
      g     <= 1'b0;
      ack   <= '0;
      data  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (seed_ld) begin
            // The all-zero state would lock the LFSR, so it maps to all-ones
            s <= (seed == '0) ? '1 : seed;
          end else if (req != 2'b00) begin
            if (req == 2'b01)      g <= 1'b0;
            else if (req == 2'b10) g <= 1'b1;
            else                   g <= ~last;
            cnt   <= CW'(STEPS - 1);
            state <= STEP;
            busy  <= 1'b1;
          end
        end
        STEP: begin
          s <= s_nxt;
          if (cnt == '0) begin
            state <= DONE;
            data  <= s_nxt;
            ack   <= g ? 2'b10 : 2'b01;
            last  <= g;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          ack   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          ack   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rr_ctrl.sv
// Self-checking bench for lfsr_rr_ctrl: a STEPS=3 instance for most scenarios
// and a STEPS=1 instance for the full-period walk.
module tb_lfsr_rr_ctrl;

  localparam int unsigned STEPS = 3;

  logic       clk;
  logic       rst_b;
  logic [1:0] req;
  logic       seed_ld;
  logic [4:0] seed;
  logic [1:0] ack;
  logic [4:0] data;
  logic       busy;

  logic [1:0] req1;
  logic       seed_ld1;
  logic [4:0] seed1;
  logic [1:0] ack1;
  logic [4:0] data1;
  logic       busy1;

  int errs;
  int checks;

  // reference model: LFSR as multiplication by x modulo x^5+x^2+1
  logic [4:0] m_s;
  int         m_last;
  logic [4:0] m1_s;

  lfsr_rr_ctrl #(.STEPS(STEPS)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .seed_ld(seed_ld), .seed(seed),
    .ack(ack), .data(data), .busy(busy)
  );

  lfsr_rr_ctrl #(.STEPS(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .req(req1), .seed_ld(seed_ld1), .seed(seed1),
    .ack(ack1), .data(data1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] mul_x(input logic [4:0] v);
    logic [5:0] t;
    t = {v, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0];
  endfunction

  function automatic logic [4:0] mul_xn(input logic [4:0] v, input int n);
    logic [4:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = mul_x(r);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_s    = 5'b11111;
    m_last = 1;
    m1_s   = 5'b11111;
  endtask

  // Drive request pattern r, serve every pending requester, drop each on its ack.
  task automatic run_req(input logic [1:0] r, output logic [4:0] last_data,
                         output int first_g);
    logic [1:0] pend;
    logic [4:0] exp;
    int         g;
    int         n;
    bit         first;
    pend  = r;
    req   = r;
    first = 1'b1;
    first_g = -1;
    last_data = '0;
    while (pend != 2'b00) begin
      if (pend == 2'b01)      g = 0;
      else if (pend == 2'b10) g = 1;
      else                    g = 1 - m_last;
      if (first) first_g = g;
      first  = 1'b0;
      exp    = mul_xn(m_s, STEPS);
      m_s    = exp;
      m_last = g;
      tick();
      checks++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL busy_after_grant: got %b want 1", busy);
      end
      n = 0;
      while (ack === 2'b00 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (n != STEPS) begin
        errs++;
        $display("FAIL ack_latency: got %0d edges want %0d", n, STEPS);
      end
      checks++;
      if (ack !== (g == 1 ? 2'b10 : 2'b01)) begin
        errs++;
        $display("FAIL ack_grant: got %b want grant %0d", ack, g);
      end
      checks++;
      if (data !== exp) begin
        errs++;
        $display("FAIL ack_data: got %b want %b", data, exp);
      end
      last_data = data;
      pend[g] = 1'b0;
      req = pend;
      tick();
      checks++;
      if (ack !== 2'b00 || busy !== 1'b0 || data !== exp) begin
        errs++;
        $display("FAIL done_to_idle: ack=%b busy=%b data=%b want 00 0 %b",
                 ack, busy, data, exp);
      end
    end
  endtask

  task automatic load_seed(input logic [4:0] v);
    seed_ld = 1'b1;
    seed    = v;
    tick();
    seed_ld = 1'b0;
    m_s = (v == 5'd0) ? 5'b11111 : v;
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL seed_stays_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    req = '0; seed_ld = 1'b0; seed = '0;
    req1 = '0; seed_ld1 = 1'b0; seed1 = '0;
    tick();
    tick();
    checks++;
    if (ack !== 2'b00 || data !== 5'd0 || busy !== 1'b0 ||
        ack1 !== 2'b00 || data1 !== 5'd0 || busy1 !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: ack=%b data=%b busy=%b ack1=%b data1=%b busy1=%b",
               ack, data, busy, ack1, data1, busy1);
    end
    rst_b = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_first_req();
    logic [4:0] d;
    int g;
    run_req(2'b01, d, g);
    checks++;
    if (d !== 5'b00011) begin
      errs++;
      $display("FAIL first_req_data: got %b want 00011", d);
    end
  endtask

  task automatic test_both_held();
    logic [4:0] d;
    int g;
    run_req(2'b11, d, g);
    checks++;
    if (g != 1) begin
      errs++;
      $display("FAIL rr_first_grant: got %0d want 1", g);
    end
    checks++;
    if (d !== 5'b11110) begin
      errs++;
      $display("FAIL rr_second_data: got %b want 11110", d);
    end
  endtask

  task automatic test_seed();
    logic [4:0] d;
    logic [4:0] v;
    int g;
    load_seed(5'd0);
    run_req(2'b10, d, g);
    checks++;
    if (d !== 5'b00011) begin
      errs++;
      $display("FAIL seed_zero_data: got %b want 00011", d);
    end
    // seed_ld and req together: load wins, grant follows on the next edge
    v = 5'($urandom_range(1, 31));
    seed_ld = 1'b1;
    seed    = v;
    req     = 2'b01;
    tick();
    seed_ld = 1'b0;
    m_s = v;
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL seed_priority: busy=%b want 0", busy);
    end
    run_req(2'b01, d, g);
  endtask

  task automatic test_steps1_period();
    int n;
    int acks;
    bit zero_seen;
    seed_ld1 = 1'b1;
    seed1    = 5'b00001;
    tick();
    seed_ld1 = 1'b0;
    m1_s = 5'b00001;
    req1 = 2'b01;
    tick();
    tick();
    m1_s = mul_x(m1_s);
    checks++;
    if (ack1 !== 2'b01 || data1 !== 5'b00010) begin
      errs++;
      $display("FAIL steps1_first: ack=%b data=%b want 01 00010", ack1, data1);
    end
    acks = 1;
    n = 0;
    zero_seen = 1'b0;
    tick();
    while (acks < 31 && n < 400) begin
      tick();
      n++;
      if (ack1 !== 2'b00) begin
        acks++;
        m1_s = mul_x(m1_s);
        if (data1 === 5'd0) zero_seen = 1'b1;
        checks++;
        if (ack1 !== 2'b01 || data1 !== m1_s) begin
          errs++;
          $display("FAIL steps1_walk: ack=%b data=%b want 01 %b", ack1, data1, m1_s);
        end
      end
    end
    req1 = 2'b00;
    checks++;
    if (acks != 31 || data1 !== 5'b00001 || zero_seen) begin
      errs++;
      $display("FAIL steps1_period: acks=%0d data=%b zero=%0d want 31 00001 0",
               acks, data1, zero_seen);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_step();
    logic [4:0] d;
    int g;
    bit bad;
    req = 2'b01;
    tick();
    tick();
    rst_b = 1'b0;
    req = 2'b00;
    #1;
    checks++;
    if (ack !== 2'b00 || busy !== 1'b0 || data !== 5'd0) begin
      errs++;
      $display("FAIL async_reset: ack=%b busy=%b data=%b want 00 0 00000", ack, busy, data);
    end
    tick();
    rst_b = 1'b1;
    model_reset();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack !== 2'b00 || ack1 !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errs++;
      $display("FAIL no_ack_after_reset: got an ack want none");
    end
    run_req(2'b01, d, g);
    checks++;
    if (d !== 5'b00011) begin
      errs++;
      $display("FAIL post_reset_data: got %b want 00011", d);
    end
  endtask

  task automatic test_drop_and_seed_in_step();
    logic [4:0] exp;
    logic [4:0] d;
    int n;
    int g;
    exp = mul_xn(m_s, STEPS);
    m_s = exp;
    m_last = 0;
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    seed_ld = 1'b1;
    seed = 5'($urandom_range(1, 31));
    n = 1;
    while (ack === 2'b00 && n < 40) begin
      tick();
      seed_ld = 1'b0;
      n++;
    end
    seed_ld = 1'b0;
    checks++;
    if (ack !== 2'b01 || data !== exp || n != STEPS) begin
      errs++;
      $display("FAIL drop_mid_step: ack=%b data=%b lat=%0d want 01 %b %0d",
               ack, data, n, exp, STEPS);
    end
    tick();
    run_req(2'b10, d, g);
  endtask

  task automatic test_random();
    logic [4:0] d;
    int g;
    int a;
    for (int it = 0; it < 25; it++) begin
      a = $urandom_range(0, 3);
      if (a == 0) load_seed(5'($urandom_range(0, 31)));
      else run_req(2'(a), d, g);
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_b = 1'b0;
    test_reset();
    test_first_req();
    test_both_held();
    test_seed();
    test_steps1_period();
    test_reset_mid_step();
    test_drop_and_seed_in_step();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
